// File: rtl/proc_pkg.sv
// Shared definitions for the execution controller: instruction fields, opcodes, FSM states.
package proc_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned INSTR_W    = 16;
    localparam int unsigned CODOP_W    = 5;
    localparam int unsigned FIELD_W    = 4;

    localparam int unsigned OPC_LSB = 12;
    localparam int unsigned RC_LSB  = 8;
    localparam int unsigned RA_LSB  = 4;
    localparam int unsigned RB_LSB  = 0;

    localparam logic [FIELD_W-1:0] OP_ADD         = 4'd0;
    localparam logic [FIELD_W-1:0] OP_SUB         = 4'd1;
    localparam logic [FIELD_W-1:0] OP_AND         = 4'd2;
    localparam logic [FIELD_W-1:0] OP_OR          = 4'd3;
    localparam logic [FIELD_W-1:0] OP_XOR         = 4'd4;
    localparam logic [FIELD_W-1:0] OP_MOV         = 4'd5;
    localparam logic [FIELD_W-1:0] OP_ADDI        = 4'd6;
    localparam logic [FIELD_W-1:0] OP_SUBI        = 4'd7;
    localparam logic [FIELD_W-1:0] OP_ANDI        = 4'd8;
    localparam logic [FIELD_W-1:0] OP_ORI         = 4'd9;
    localparam logic [FIELD_W-1:0] OP_IMM_LAST    = 4'd10;
    localparam logic [FIELD_W-1:0] OP_ILLEGAL_MIN = 4'd11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_READ,
        ST_EXEC,
        ST_WRITE
    } state_e;

    function automatic logic [FIELD_W-1:0] field(input logic [INSTR_W-1:0] ins,
                                                 input int unsigned lsb);
        return ins[lsb +: FIELD_W];
    endfunction

endpackage

// File: rtl/exec_decode.sv
// Combinational instruction decoder: register addresses, ALU opcode/immediate, class flags.
module exec_decode
    import proc_pkg::*;
(
    input  logic [INSTR_W-1:0]    instr_i,
    output logic [REG_ADDR_W-1:0] addr_a_o,
    output logic [REG_ADDR_W-1:0] addr_b_o,
    output logic [REG_ADDR_W-1:0] addr_c_o,
    output logic [CODOP_W-1:0]    codop_o,
    output logic [DATA_W-1:0]     imm_o,
    output logic                  is_imm_o,
    output logic                  is_illegal_o
);

    logic [FIELD_W-1:0] opc;

    always_comb begin
        opc          = field(instr_i, OPC_LSB);
        is_illegal_o = (opc >= OP_ILLEGAL_MIN);
        is_imm_o     = (opc >= OP_ADDI) && (opc <= OP_IMM_LAST);
        addr_a_o     = {1'b0, field(instr_i, RA_LSB)};
        addr_b_o     = {1'b0, field(instr_i, RB_LSB)};
        addr_c_o     = {1'b0, field(instr_i, RC_LSB)};
        codop_o      = {1'b0, opc};
        imm_o        = '0;
        if (is_imm_o) begin
            imm_o = {{(DATA_W-FIELD_W){1'b0}}, field(instr_i, RA_LSB)};
        end
    end

endmodule

// File: rtl/exec_controller.sv
// Sequencer for register bank + ALU: accept, decode, wait read/ALU latency, write back once.
// Optional perf counters (retired_cnt, illegal_cnt) when EXEC_CTRL_PERF_CNT_EN is defined.
module exec_controller
    import proc_pkg::*;
#(
    parameter int unsigned RD_LAT  = 1,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic                  CLOCK_50,
    input  logic                  reset_n,
    input  logic                  instr_valid,
    input  logic [INSTR_W-1:0]    instr,
    output logic                  instr_ready,
    output logic [REG_ADDR_W-1:0] reg_a_addr,
    output logic [REG_ADDR_W-1:0] reg_b_addr,
    output logic [REG_ADDR_W-1:0] reg_c_addr,
    output logic                  bank_rw,
    output logic [DATA_W-1:0]     bank_wdata,
    output logic [CODOP_W-1:0]    alu_codop,
    output logic [DATA_W-1:0]     alu_imm,
    input  logic [DATA_W-1:0]     alu_result,
    output logic                  busy,
    output logic                  done,
    output logic                  illegal_op
`ifdef EXEC_CTRL_PERF_CNT_EN
    ,
    output logic [15:0]           retired_cnt,
    output logic [15:0]           illegal_cnt
`endif
);

    localparam int unsigned CNT_W = 2;

    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [INSTR_W-1:0]    instr_q;
    logic                  ready_q;
    logic [REG_ADDR_W-1:0] addr_a_q, addr_b_q, addr_c_q;
    logic [CODOP_W-1:0]    codop_q;
    logic [DATA_W-1:0]     imm_q, wdata_q;
    logic                  bank_rw_q, done_q, illegal_q;

    logic [REG_ADDR_W-1:0] dec_addr_a, dec_addr_b, dec_addr_c;
    logic [CODOP_W-1:0]    dec_codop;
    logic [DATA_W-1:0]     dec_imm;
    logic                  dec_is_imm, dec_is_illegal;

    exec_decode u_decode (
        .instr_i      (instr_q),
        .addr_a_o     (dec_addr_a),
        .addr_b_o     (dec_addr_b),
        .addr_c_o     (dec_addr_c),
        .codop_o      (dec_codop),
        .imm_o        (dec_imm),
        .is_imm_o     (dec_is_imm),
        .is_illegal_o (dec_is_illegal)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            instr_q   <= '0;
            ready_q   <= 1'b1;
            addr_a_q  <= '0;
            addr_b_q  <= '0;
            addr_c_q  <= '0;
            codop_q   <= '0;
            imm_q     <= '0;
            wdata_q   <= '0;
            bank_rw_q <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            bank_rw_q <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (instr_valid) begin
                        instr_q <= instr;
                        ready_q <= 1'b0;
                        state_q <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    // Illegal opcodes leave the datapath outputs untouched.
                    if (dec_is_illegal) begin
                        done_q    <= 1'b1;
                        illegal_q <= 1'b1;
                        ready_q   <= 1'b1;
                        state_q   <= ST_IDLE;
                    end else begin
                        addr_a_q <= dec_is_imm ? '0 : dec_addr_a;
                        addr_b_q <= dec_addr_b;
                        addr_c_q <= dec_addr_c;
                        codop_q  <= dec_codop;
                        imm_q    <= dec_imm;
                        cnt_q    <= CNT_W'(RD_LAT - 1);
                        state_q  <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (cnt_q == '0) begin
                        cnt_q   <= CNT_W'(ALU_LAT - 1);
                        state_q <= ST_EXEC;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (cnt_q == '0) begin
                        wdata_q   <= alu_result;
                        bank_rw_q <= 1'b1;
                        done_q    <= 1'b1;
                        state_q   <= ST_WRITE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_WRITE: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign instr_ready = ready_q;
    assign reg_a_addr  = addr_a_q;
    assign reg_b_addr  = addr_b_q;
    assign reg_c_addr  = addr_c_q;
    assign alu_codop   = codop_q;
    assign alu_imm     = imm_q;
    assign bank_wdata  = wdata_q;
    assign bank_rw     = bank_rw_q;
    assign done        = done_q;
    assign illegal_op  = illegal_q;
    assign busy        = (state_q != ST_IDLE);

`ifdef EXEC_CTRL_PERF_CNT_EN
    logic [15:0] retired_q, illegal_cnt_q;

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            retired_q     <= '0;
            illegal_cnt_q <= '0;
        end else begin
            if (state_q == ST_WRITE) retired_q <= retired_q + 16'd1;
            if (illegal_q) illegal_cnt_q <= illegal_cnt_q + 16'd1;
        end
    end

    assign retired_cnt = retired_q;
    assign illegal_cnt = illegal_cnt_q;
`endif

endmodule

// File: tb/tb_exec_controller.sv
// Scoreboard bench for exec_controller: bank/ALU model (op0 = A+B, op6 = imm+B), timing and reset checks.
// A second instance runs with RD_LAT=2, ALU_LAT=3; counter checks only when EXEC_CTRL_PERF_CNT_EN is defined.
module tb_exec_controller;

    logic        CLOCK_50 = 1'b0;
    logic        reset_n;
    logic        instr_valid, instr_valid2;
    logic [15:0] instr;

    logic        instr_ready, bank_rw, busy, done, illegal_op;
    logic [4:0]  reg_a_addr, reg_b_addr, reg_c_addr, alu_codop;
    logic [15:0] bank_wdata, alu_imm, alu_result;

    logic        instr_ready2, bank_rw2, busy2, done2, illegal_op2;
    logic [4:0]  reg_a_addr2, reg_b_addr2, reg_c_addr2, alu_codop2;
    logic [15:0] bank_wdata2, alu_imm2, alu_result2;
`ifdef EXEC_CTRL_PERF_CNT_EN
    logic [15:0] retired_cnt, illegal_cnt, retired_cnt2, illegal_cnt2;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Bank model for the default instance; preloads go through the same process as write-backs.
    logic [15:0] regs [32] = '{default: 16'h0000};
    logic        pre_en = 1'b0;
    logic [4:0]  pre_addr = '0;
    logic [15:0] pre_data = '0;

    typedef struct {
        logic [4:0]  addr;
        logic [15:0] data;
        int          t;
    } wb_t;
    wb_t sb[$];
    wb_t mon_e;

    always #10 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    assign alu_result  = (alu_codop == 5'd6) ? alu_imm + regs[reg_b_addr]
                                             : regs[reg_a_addr] + regs[reg_b_addr];
    // Second instance sees a bank where every register holds its own index.
    assign alu_result2 = 16'(reg_a_addr2) + 16'(reg_b_addr2);

    exec_controller u_dut (
        .CLOCK_50    (CLOCK_50),
        .reset_n     (reset_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .reg_a_addr  (reg_a_addr),
        .reg_b_addr  (reg_b_addr),
        .reg_c_addr  (reg_c_addr),
        .bank_rw     (bank_rw),
        .bank_wdata  (bank_wdata),
        .alu_codop   (alu_codop),
        .alu_imm     (alu_imm),
        .alu_result  (alu_result),
        .busy        (busy),
        .done        (done),
        .illegal_op  (illegal_op)
`ifdef EXEC_CTRL_PERF_CNT_EN
        ,
        .retired_cnt (retired_cnt),
        .illegal_cnt (illegal_cnt)
`endif
    );

    exec_controller #(.RD_LAT(2), .ALU_LAT(3)) u_dut2 (
        .CLOCK_50    (CLOCK_50),
        .reset_n     (reset_n),
        .instr_valid (instr_valid2),
        .instr       (instr),
        .instr_ready (instr_ready2),
        .reg_a_addr  (reg_a_addr2),
        .reg_b_addr  (reg_b_addr2),
        .reg_c_addr  (reg_c_addr2),
        .bank_rw     (bank_rw2),
        .bank_wdata  (bank_wdata2),
        .alu_codop   (alu_codop2),
        .alu_imm     (alu_imm2),
        .alu_result  (alu_result2),
        .busy        (busy2),
        .done        (done2),
        .illegal_op  (illegal_op2)
`ifdef EXEC_CTRL_PERF_CNT_EN
        ,
        .retired_cnt (retired_cnt2),
        .illegal_cnt (illegal_cnt2)
`endif
    );

    always @(posedge CLOCK_50) begin
        if (bank_rw === 1'b1) regs[reg_c_addr] <= bank_wdata;
        else if (pre_en) regs[pre_addr] <= pre_data;
    end

    // Sampling #1 after edge e observes cycle e+1 (cycle N+1 is the one following accept edge N).
    always @(posedge CLOCK_50) begin
        #1;
        if (bank_rw === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: bank_rw=1 addr=%0d data=%h at cycle %0d, required no write",
                         reg_c_addr, bank_wdata, cyc + 1);
            end else begin
                mon_e = sb.pop_front();
                if (reg_c_addr !== mon_e.addr || bank_wdata !== mon_e.data || (cyc + 1) != mon_e.t) begin
                    errors++;
                    $display("FAIL writeback: got addr=%0d data=%h cycle=%0d, required addr=%0d data=%h cycle=%0d",
                             reg_c_addr, bank_wdata, cyc + 1, mon_e.addr, mon_e.data, mon_e.t);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic preload(input logic [4:0] a, input logic [15:0] d);
        pre_addr = a;
        pre_data = d;
        pre_en   = 1'b1;
        tick();
        pre_en   = 1'b0;
    endtask

    task automatic issue(input logic [15:0] ins, output int acc);
        int w;
        w = 0;
        while (instr_ready !== 1'b1 && w < 40) begin
            tick();
            w++;
        end
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_wait: instr_ready=%b, required 1 within 40 cycles", instr_ready);
        end
        instr       = ins;
        instr_valid = 1'b1;
        tick();
        acc         = cyc;
        instr_valid = 1'b0;
        instr       = 16'($urandom);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 40) begin
            tick();
            w++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d write-backs still pending, required 0", sb.size());
        end
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({instr_ready, busy, bank_rw, done, illegal_op} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl: ready/busy/rw/done/ill=%b, required 10000",
                     {instr_ready, busy, bank_rw, done, illegal_op});
        end
        checks++;
        if ({reg_a_addr, reg_b_addr, reg_c_addr, alu_codop} !== 20'd0 || alu_imm !== 16'd0 || bank_wdata !== 16'd0) begin
            errors++;
            $display("FAIL reset_data: a=%0d b=%0d c=%0d op=%0d imm=%h wdata=%h, required all 0",
                     reg_a_addr, reg_b_addr, reg_c_addr, alu_codop, alu_imm, bank_wdata);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_add();
        int acc;
        logic [3:0] exp;
        preload(5'd1, 16'h0003);
        preload(5'd2, 16'h0005);
        issue(16'h0312, acc);
        sb.push_back('{5'd3, 16'h0008, acc + 4});
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) tick();
            exp = {1'(k == 4), 1'(k == 4), 1'(k <= 4), 1'(k >= 5)};
            checks++;
            if ({bank_rw, done, busy, instr_ready} !== exp) begin
                errors++;
                $display("FAIL add_timing: cycle N+%0d rw/done/busy/ready=%b, required %b",
                         k, {bank_rw, done, busy, instr_ready}, exp);
            end
            if (k == 4) begin
                checks++;
                if (reg_c_addr !== 5'd3 || reg_a_addr !== 5'd1 || reg_b_addr !== 5'd2 || alu_codop !== 5'd0) begin
                    errors++;
                    $display("FAIL add_addr: c=%0d a=%0d b=%0d op=%0d, required 3 1 2 0",
                             reg_c_addr, reg_a_addr, reg_b_addr, alu_codop);
                end
            end
        end
    endtask

    task automatic test_imm();
        int acc, w;
        preload(5'd2, 16'h0010);
        issue(16'h64A2, acc);
        sb.push_back('{5'd4, 16'h001A, acc + 4});
        w = 0;
        while (bank_rw !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        checks++;
        if (alu_imm !== 16'h000A || alu_imm[15:4] !== 12'd0) begin
            errors++;
            $display("FAIL imm_value: alu_imm=%h, required 000a", alu_imm);
        end
        checks++;
        if (reg_b_addr !== 5'd2 || reg_a_addr !== 5'd0 || reg_c_addr !== 5'd4 || alu_codop !== 5'd6) begin
            errors++;
            $display("FAIL imm_addr: b=%0d a=%0d c=%0d op=%0d, required 2 0 4 6",
                     reg_b_addr, reg_a_addr, reg_c_addr, alu_codop);
        end
        drain();
    endtask

    task automatic test_illegal();
        int acc;
        logic [4:0] exp;
        issue(16'hB123, acc);
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) tick();
            exp = {1'b0, 1'(k == 2), 1'(k == 2), 1'(k == 1), 1'(k >= 2)};
            checks++;
            if ({bank_rw, done, illegal_op, busy, instr_ready} !== exp) begin
                errors++;
                $display("FAIL illegal_timing: cycle N+%0d rw/done/ill/busy/ready=%b, required %b",
                         k, {bank_rw, done, illegal_op, busy, instr_ready}, exp);
            end
        end
    endtask

`ifdef EXEC_CTRL_PERF_CNT_EN
    task automatic test_perf(input logic [15:0] exp_ret, input logic [15:0] exp_ill);
        checks++;
        if (retired_cnt !== exp_ret || illegal_cnt !== exp_ill) begin
            errors++;
            $display("FAIL perf_cnt: retired=%0d illegal=%0d, required %0d %0d",
                     retired_cnt, illegal_cnt, exp_ret, exp_ill);
        end
    endtask
`endif

    task automatic test_back_to_back();
        int acc1, acc2;
        logic r, got;
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: instr_ready=%b, required 1", instr_ready);
        end
        instr       = 16'h0512;
        instr_valid = 1'b1;
        tick();
        acc1 = cyc;
        sb.push_back('{5'd5, 16'h0013, acc1 + 4});
        instr = 16'h0654;
        acc2  = 0;
        got   = 1'b0;
        for (int w = 0; w < 20 && !got; w++) begin
            r = instr_ready;
            tick();
            if (r === 1'b1) begin
                acc2 = cyc;
                got  = 1'b1;
            end
        end
        instr_valid = 1'b0;
        checks++;
        if (!got || acc2 != acc1 + 5) begin
            errors++;
            $display("FAIL b2b_accept: second accept at edge %0d, required %0d", acc2, acc1 + 5);
        end
        sb.push_back('{5'd6, 16'h002D, acc2 + 4});
        drain();
    endtask

    task automatic test_reset_mid();
        int acc;
        issue(16'h0312, acc);
        tick();
        tick();
        checks++;
        if (busy !== 1'b1 || bank_rw !== 1'b0) begin
            errors++;
            $display("FAIL mid_exec: busy=%b rw=%b in EXEC, required 1 0", busy, bank_rw);
        end
        reset_n = 1'b0;
        tick();
        checks++;
        if ({instr_ready, busy, bank_rw, done, illegal_op} !== 5'b10000 ||
            {reg_a_addr, reg_b_addr, reg_c_addr, alu_codop} !== 20'd0 ||
            alu_imm !== 16'd0 || bank_wdata !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset: ctrl=%b a=%0d b=%0d c=%0d op=%0d imm=%h wdata=%h, required 10000 and zeros",
                     {instr_ready, busy, bank_rw, done, illegal_op}, reg_a_addr, reg_b_addr,
                     reg_c_addr, alu_codop, alu_imm, bank_wdata);
        end
        reset_n = 1'b1;
        repeat (4) tick();
        issue(16'h0712, acc);
        sb.push_back('{5'd7, 16'h0013, acc + 4});
        drain();
    endtask

    task automatic test_latency();
        int acc;
        checks++;
        if (instr_ready2 !== 1'b1) begin
            errors++;
            $display("FAIL lat_ready: instr_ready2=%b, required 1", instr_ready2);
        end
        instr        = 16'h0312;
        instr_valid2 = 1'b1;
        tick();
        acc          = cyc;
        instr_valid2 = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            if (k > 1) tick();
            checks++;
            if ({bank_rw2, done2} !== {1'(k == 7), 1'(k == 7)}) begin
                errors++;
                $display("FAIL lat_timing: cycle N+%0d rw/done=%b, required %b",
                         k, {bank_rw2, done2}, {1'(k == 7), 1'(k == 7)});
            end
            if (k == 7) begin
                checks++;
                if (bank_wdata2 !== 16'h0003 || reg_c_addr2 !== 5'd3) begin
                    errors++;
                    $display("FAIL lat_data: wdata=%h c=%0d, required 0003 3", bank_wdata2, reg_c_addr2);
                end
            end
        end
`ifdef EXEC_CTRL_PERF_CNT_EN
        checks++;
        if (retired_cnt2 !== 16'd1) begin
            errors++;
            $display("FAIL lat_retired: retired_cnt=%0d, required 1", retired_cnt2);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_n      = 1'b0;
        instr_valid  = 1'b0;
        instr_valid2 = 1'b0;
        instr        = '0;
        test_reset();
        test_add();
        test_imm();
        test_illegal();
`ifdef EXEC_CTRL_PERF_CNT_EN
        test_perf(16'd2, 16'd1);
`endif
        test_back_to_back();
        test_reset_mid();
`ifdef EXEC_CTRL_PERF_CNT_EN
        test_perf(16'd1, 16'd0);
`endif
        test_latency();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
